// File: rtl/tnn_pkg.sv
// rtl/tnn_pkg.sv - shared constants, FSM state type and helpers for the popcount scheduler
// Ports: none (package).
package tnn_pkg;

    localparam int PC_W  = 24;  // popcount operand width
    localparam int CNT_W = 5;   // popcount result width (0..31 trusted)
    localparam int SUM_W = 6;   // signed pos-neg difference width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POS  = 2'd1,
        NEG  = 2'd2,
        OUT  = 2'd3
    } sched_state_t;

    // Index width that never collapses to zero bits.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tnn_rr_arb.sv
// rtl/tnn_rr_arb.sv - combinational round-robin arbiter, first set request at or above ptr
// Ports:
//   i_req    - request vector
//   i_ptr    - search start index (owned by the caller)
//   i_enable - when low no grant is issued
//   o_grant  - one-hot grant
//   o_idx    - encoded index of the granted requester
module tnn_rr_arb
    import tnn_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int ID_W = clog2_safe(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    input  logic            i_enable,
    output logic [NREQ-1:0] o_grant,
    output logic [ID_W-1:0] o_idx
);

    always_comb begin
        logic w_found;
        int   j;
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        j       = 0;
        // Walk NREQ positions starting at ptr; the first hit wins.
        for (int k = 0; k < NREQ; k++) begin
            j = int'(i_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (i_enable && !w_found && i_req[j]) begin
                w_found    = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/tnn_popcount_sched.sv
// rtl/tnn_popcount_sched.sv - round-robin scheduler sharing one popcount unit among ternary neurons
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   req_valid/req_ready - per-requester request handshake (ready is a one-hot accept strobe)
//   req_pos/req_neg     - per-requester +1 / -1 match vectors, slice i at [24i+23:24i]
//   req_thr             - per-requester signed threshold
//   pc_a/pc_count       - operand to / count from the external combinational popcount unit
//   res_valid/res_ready - result handshake
//   res_id/res_sum/res_fire - owner, signed pos-neg difference, sum >= threshold
module tnn_popcount_sched
    import tnn_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int THR_W = 6,
    localparam int ID_W  = clog2_safe(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*PC_W-1:0]  req_pos,
    input  logic [NREQ*PC_W-1:0]  req_neg,
    input  logic [NREQ*THR_W-1:0] req_thr,
    output logic [PC_W-1:0]       pc_a,
    input  logic [CNT_W-1:0]      pc_count,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ID_W-1:0]       res_id,
    output logic [SUM_W-1:0]      res_sum,
    output logic                  res_fire
);

    // Compare width: the wider of sum and threshold, so both sign-extend.
    localparam int CMP_W = (THR_W > SUM_W) ? THR_W : SUM_W;

    sched_state_t r_state;
    sched_state_t w_next_state;

    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_id;
    logic [PC_W-1:0]  r_pos;
    logic [PC_W-1:0]  r_neg;
    logic [THR_W-1:0] r_thr;
    logic [CNT_W-1:0] r_pos_cnt;
    logic [SUM_W-1:0] r_sum;
    logic             r_fire;

    logic [NREQ-1:0]  w_grant;
    logic [ID_W-1:0]  w_idx;
    logic             w_accept;
    logic [PC_W-1:0]  w_sel_pos;
    logic [PC_W-1:0]  w_sel_neg;
    logic [THR_W-1:0] w_sel_thr;
    logic [SUM_W-1:0] w_diff;
    logic signed [CMP_W-1:0] w_sum_ext;
    logic signed [CMP_W-1:0] w_thr_ext;
    logic             w_fire;
    logic             w_res_hs;
    logic [ID_W-1:0]  w_ptr_next;

    tnn_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .i_req    (req_valid),
        .i_ptr    (r_ptr),
        .i_enable (r_state == IDLE),
        .o_grant  (w_grant),
        .o_idx    (w_idx)
    );

    assign req_ready = w_grant;
    assign w_accept  = |w_grant;

    assign w_sel_pos = req_pos[int'(w_idx)*PC_W +: PC_W];
    assign w_sel_neg = req_neg[int'(w_idx)*PC_W +: PC_W];
    assign w_sel_thr = req_thr[int'(w_idx)*THR_W +: THR_W];

    // Both counts are at most 31, so the 6-bit difference cannot overflow.
    assign w_diff    = {1'b0, r_pos_cnt} - {1'b0, pc_count};
    assign w_sum_ext = CMP_W'($signed(w_diff));
    assign w_thr_ext = CMP_W'($signed(r_thr));
    assign w_fire    = (w_sum_ext >= w_thr_ext);

    assign res_valid  = (r_state == OUT);
    assign w_res_hs   = res_valid && res_ready;
    assign w_ptr_next = (r_id == ID_W'(NREQ - 1)) ? '0 : r_id + 1'b1;

    assign res_id   = r_id;
    assign res_sum  = r_sum;
    assign res_fire = r_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        pc_a         = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = POS;
                end
            end
            POS: begin
                pc_a         = r_pos;
                w_next_state = NEG;
            end
            NEG: begin
                pc_a         = r_neg;
                w_next_state = OUT;
            end
            OUT: begin
                if (res_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_id      <= '0;
            r_pos     <= '0;
            r_neg     <= '0;
            r_thr     <= '0;
            r_pos_cnt <= '0;
            r_sum     <= '0;
            r_fire    <= 1'b0;
        end else begin
            if (w_accept) begin
                // A bit present in both vectors is a zero weight: drop it from both.
                r_pos <= w_sel_pos & ~w_sel_neg;
                r_neg <= w_sel_neg & ~w_sel_pos;
                r_thr <= w_sel_thr;
                r_id  <= w_idx;
            end
            if (r_state == POS) begin
                r_pos_cnt <= pc_count;
            end
            if (r_state == NEG) begin
                r_sum  <= w_diff;
                r_fire <= w_fire;
            end
            if (w_res_hs) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

endmodule
